td4_prog_loader: RTL and testbench
==================================

# td4_prog_loader

Writable 16×8 program memory for the TD4 CPU, with a switch-and-button loader. It is the write side of the CPU's instruction-fetch port. In load mode it captures one byte from the board switches per debounced button press into successive addresses, and holds the CPU in reset. In run mode it serves instruction bytes combinationally to the CPU fetch address.

## Interface
- DEBOUNCE_CYCLES, 50000: number of consecutive cycles a synchronized button level must stay stable before it is accepted (1 ms at 50 MHz).
- CLK  in  1  system clock.
- RST  in  1  reset; asynchronous assertion, active-low.
- load_en  in  1  level from a slide switch; 1 = load mode, 0 = run mode.
- wr_btn_n  in  1  raw push button, active-low, bouncy and asynchronous.
- data_in  in  8  byte to write: opcode in [7:4], immediate in [3:0].
- rd_addr  in  4  CPU fetch address (the PC).
- rd_data  out  8  mem[rd_addr]; combinational.
- cpu_hold  out  1  drives the CPU reset; 1 whenever the CPU must not run.
- wr_ptr  out  4  next address to be written; intended for the HEX display.
- wr_ack  out  1  one-cycle pulse in the cycle a byte is written.
- full  out  1  all 16 locations written since load mode was entered.

## Operation
- **Memory.** 16 entries × 8 bits, held in flops. Reset clears all entries to 0x00. Reads are always live, including during load.
- **Button path.** A 2-flop synchronizer feeds a stable-level counter. The debounced level changes only after DEBOUNCE_CYCLES identical synchronized samples. `press` pulses for one cycle on each debounced high→low transition. A held button produces exactly one press.
- **State HOLD** (reset state):
  - cpu_hold=1.
  - Next state: LOAD if load_en=1, otherwise RUN.
- **State RUN:**
  - cpu_hold=0. Presses are ignored.
  - load_en=1 → LOAD, with wr_ptr←0 and full←0.
- **State LOAD:**
  - cpu_hold=1.
  - load_en=0 → HOLD. Exit has priority over a simultaneous press, so no write occurs in that case.
  - Otherwise, press → WRITE.
- **State WRITE** (exactly one cycle):
  - mem[wr_ptr]←data_in; wr_ack=1; wr_ptr←wr_ptr+1 (4-bit, wraps 15→0).
  - If the pre-increment wr_ptr was 15: full←1 and go to FULL. Otherwise go to LOAD.
  - data_in is sampled in this cycle, not at the press.
- **State FULL:**
  - cpu_hold=1. Presses are ignored and memory is unchanged.
  - load_en=0 → HOLD.
- **Mode-switch timing.** HOLD guarantees at least one cycle of cpu_hold=1 between leaving load mode and running. This means the CPU always restarts from PC=0 after a load.
- **Outputs.** cpu_hold, wr_ack and full are decoded from registered state/flags. There are no combinational paths from inputs, except rd_addr→rd_data.

## Timing
- **Reset values:** state=HOLD, cpu_hold=1, wr_ptr=0, wr_ack=0, full=0, rd_data=0x00. The debouncer resets to the released level (1), with its counter at 0.
- **Press latency:** press fires 2 + DEBOUNCE_CYCLES cycles after wr_btn_n goes stably low. WRITE occurs in the next cycle, and wr_ptr/rd_data update in the cycle after that.
- **Glitches:** a low or high glitch shorter than DEBOUNCE_CYCLES restarts the counter and produces no press.
- **Run-mode latency:** load_en 1→0 gives cpu_hold=0 two cycles after the state sees it (LOAD→HOLD→RUN).
- **Reset mid-operation:** RST asserted in any state, including WRITE, immediately returns all state to reset values and clears memory. There is no partial write.

## Structure
- **Package td4_loader_pkg:**
  - state enum: HOLD, RUN, LOAD, WRITE, FULL.
  - constants: MEM_DEPTH=16, ADDR_W=4, DATA_W=8.
- **Sub-module btn_debounce:**
  - Contains the synchronizer, the stable-level counter (width $clog2(DEBOUNCE_CYCLES+1)) and the press pulse.
  - Parameterized by DEBOUNCE_CYCLES; uses the same CLK/RST.
- **Top level:** holds the FSM, the pointer and the memory array.

## Test plan
All scenarios run with DEBOUNCE_CYCLES=4.
- **Reset:** RST=0 with load_en=0 → cpu_hold=1, wr_ptr=0, full=0, rd_data=0x00 at all 16 addresses. Release RST → cpu_hold=0 one cycle later.
- **Load and run:** enter load; press three times with data_in 0x31, 0x45, 0xF0 → three wr_ack pulses, wr_ptr=3. Set load_en=0 → rd_addr=1 gives 0x45, and cpu_hold=1 for at least one cycle before falling.
- **Bounce:** 3-cycle low glitch on wr_btn_n → no wr_ack, wr_ptr unchanged. Then a clean 10-cycle press → exactly one write.
- **Wrap/full:** 16 presses with data_in = address×0x11 → full=1, wr_ptr=0. A 17th press with 0xAA → mem[0] stays 0x00 and there is no wr_ack. Re-entering load mode clears full and wr_ptr.
- **Ignored presses and simultaneous events:** a press in RUN → no write. A press pulse coincident with load_en falling in LOAD → no write, state goes to HOLD.
- **Reset mid-write:** RST asserted during the WRITE cycle → memory all 0x00, wr_ptr=0, cpu_hold=1.

Source files
------------

// File: rtl/td4_loader_pkg.sv
// Shared types and constants for the TD4 program loader.
package td4_loader_pkg;

    localparam int unsigned MEM_DEPTH = 16;
    localparam int unsigned ADDR_W    = 4;
    localparam int unsigned DATA_W    = 8;

    typedef enum logic [2:0] {
        HOLD,
        RUN,
        LOAD,
        WRITE,
        FULL
    } state_e;

    typedef logic [ADDR_W-1:0] addr_t;
    typedef logic [DATA_W-1:0] data_t;

endpackage

// File: rtl/btn_debounce.sv
// Push-button conditioner: 2-flop synchronizer, stable-level counter and a
// one-cycle press pulse on each accepted high-to-low transition.
module btn_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
    input  logic CLK,
    input  logic RST,
    input  logic btn_n,
    output logic press
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic             level_q, level_d;
    logic             press_q, press_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;

    always_comb begin
        sync1_d = btn_n;
        sync2_d = sync1_q;
        level_d = level_q;
        cnt_d   = '0;
        // Count consecutive samples that disagree with the accepted level;
        // any agreeing sample restarts the count.
        if (sync2_q != level_q) begin
            if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                level_d = sync2_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
        press_d = level_q & ~level_d;
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            level_q <= 1'b1;
            press_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            level_q <= level_d;
            press_q <= press_d;
            cnt_q   <= cnt_d;
        end
    end

    assign press = press_q;

endmodule

// File: rtl/td4_prog_loader.sv
// Writable 16x8 TD4 program memory with a switch-and-button byte loader.
module td4_prog_loader
    import td4_loader_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              load_en,
    input  logic              wr_btn_n,
    input  logic [DATA_W-1:0] data_in,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              cpu_hold,
    output logic [ADDR_W-1:0] wr_ptr,
    output logic              wr_ack,
    output logic              full
);

    state_e state_q, state_d;
    addr_t  wr_ptr_q, wr_ptr_d;
    logic   full_q,   full_d;
    data_t  mem_q [MEM_DEPTH];
    data_t  mem_d [MEM_DEPTH];
    logic   press;
    logic   enter_load;

    btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_btn_debounce (
        .CLK   (CLK),
        .RST   (RST),
        .btn_n (wr_btn_n),
        .press (press)
    );

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= HOLD;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            HOLD:    state_d = load_en ? LOAD : RUN;
            RUN:     if (load_en) state_d = LOAD;
            // Leaving load mode wins over a coincident press.
            LOAD: begin
                if (!load_en) begin
                    state_d = HOLD;
                end else if (press) begin
                    state_d = WRITE;
                end
            end
            WRITE:   state_d = (wr_ptr_q == '1) ? FULL : LOAD;
            FULL:    if (!load_en) state_d = HOLD;
            default: state_d = HOLD;
        endcase
    end

    assign enter_load = ((state_q == HOLD) || (state_q == RUN)) && (state_d == LOAD);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        full_d   = full_q;
        mem_d    = mem_q;
        if (enter_load) begin
            wr_ptr_d = '0;
            full_d   = 1'b0;
        end
        if (state_q == WRITE) begin
            mem_d[wr_ptr_q] = data_in;
            wr_ptr_d        = wr_ptr_q + addr_t'(1);
            if (wr_ptr_q == '1) begin
                full_d = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            wr_ptr_q <= '0;
            full_q   <= 1'b0;
            mem_q    <= '{default: '0};
        end else begin
            wr_ptr_q <= wr_ptr_d;
            full_q   <= full_d;
            mem_q    <= mem_d;
        end
    end

    always_comb begin
        cpu_hold = (state_q != RUN);
        wr_ack   = (state_q == WRITE);
        full     = full_q;
        wr_ptr   = wr_ptr_q;
        rd_data  = mem_q[rd_addr];
    end

endmodule

// File: tb/tb_td4_prog_loader.sv
// Randomized bench for td4_prog_loader against a loader-level model
// (memory array, pointer, full flag and mode).
module tb_td4_prog_loader;

    logic       CLK = 1'b0;
    logic       RST;
    logic       load_en;
    logic       wr_btn_n;
    logic [7:0] data_in;
    logic [3:0] rd_addr;
    logic [7:0] rd_data;
    logic       cpu_hold;
    logic [3:0] wr_ptr;
    logic       wr_ack;
    logic       full;

    int checks = 0;
    int errors = 0;

    logic [7:0] m_mem [16];
    int         m_ptr;
    bit         m_full;
    bit         m_load;

    always #5 CLK = ~CLK;

    td4_prog_loader #(
        .DEBOUNCE_CYCLES(4)
    ) dut (
        .CLK      (CLK),
        .RST      (RST),
        .load_en  (load_en),
        .wr_btn_n (wr_btn_n),
        .data_in  (data_in),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .cpu_hold (cpu_hold),
        .wr_ptr   (wr_ptr),
        .wr_ack   (wr_ack),
        .full     (full)
    );

    function automatic int m_press(input logic [7:0] d);
        if (m_load && !m_full) begin
            m_mem[m_ptr] = d;
            m_ptr = (m_ptr + 1) % 16;
            if (m_ptr == 0) m_full = 1'b1;
            return 1;
        end
        return 0;
    endfunction

    function automatic void m_reset();
        for (int i = 0; i < 16; i++) m_mem[i] = 8'h00;
        m_ptr  = 0;
        m_full = 1'b0;
        m_load = 1'b0;
    endfunction

    // Holds the button low for 'low' cycles, then high for 10; counts wr_ack.
    task automatic do_press(input int low, input logic [7:0] d, output int acks, output int first);
        data_in  = d;
        wr_btn_n = 1'b0;
        acks     = 0;
        first    = -1;
        for (int i = 1; i <= low + 10; i++) begin
            @(negedge CLK);
            if (wr_ack === 1'b1) begin
                acks++;
                if (first < 0) first = i;
            end
            if (i == low) wr_btn_n = 1'b1;
        end
    endtask

    task automatic go_run();
        load_en = 1'b0;
        repeat (3) @(negedge CLK);
        m_load = 1'b0;
    endtask

    task automatic go_load();
        load_en = 1'b1;
        repeat (2) @(negedge CLK);
        m_load = 1'b1;
        m_ptr  = 0;
        m_full = 1'b0;
    endtask

    task automatic test_reset();
        RST = 1'b0; load_en = 1'b0; wr_btn_n = 1'b1; data_in = 8'h00; rd_addr = 4'h0;
        m_reset();
        repeat (2) @(negedge CLK);
        checks++; if (cpu_hold !== 1'b1) begin errors++; $display("FAIL reset_cpu_hold got %b expected 1", cpu_hold); end
        checks++; if (wr_ptr !== 4'h0) begin errors++; $display("FAIL reset_wr_ptr got %h expected 0", wr_ptr); end
        checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full got %b expected 0", full); end
        checks++; if (wr_ack !== 1'b0) begin errors++; $display("FAIL reset_wr_ack got %b expected 0", wr_ack); end
        for (int a = 0; a < 16; a++) begin
            rd_addr = 4'(a); #1;
            checks++; if (rd_data !== 8'h00) begin errors++; $display("FAIL reset_mem[%0d] got %h expected 00", a, rd_data); end
        end
        @(negedge CLK);
        RST = 1'b1;
        #1;
        checks++; if (cpu_hold !== 1'b1) begin errors++; $display("FAIL release_hold got %b expected 1", cpu_hold); end
        @(negedge CLK);
        checks++; if (cpu_hold !== 1'b0) begin errors++; $display("FAIL release_run got %b expected 0", cpu_hold); end
    endtask

    task automatic test_load_run();
        logic [7:0] vals [3];
        int acks, first, exp;
        vals[0] = 8'h31; vals[1] = 8'h45; vals[2] = 8'hF0;
        go_load();
        checks++; if (cpu_hold !== 1'b1) begin errors++; $display("FAIL load_hold got %b expected 1", cpu_hold); end
        checks++; if (wr_ptr !== 4'h0) begin errors++; $display("FAIL load_ptr got %h expected 0", wr_ptr); end
        for (int k = 0; k < 3; k++) begin
            exp = m_press(vals[k]);
            do_press($urandom_range(4, 12), vals[k], acks, first);
            checks++; if (acks !== exp) begin errors++; $display("FAIL load_ack%0d got %0d expected %0d", k, acks, exp); end
            checks++; if (wr_ptr !== 4'(m_ptr)) begin errors++; $display("FAIL load_ptr%0d got %h expected %h", k, wr_ptr, 4'(m_ptr)); end
            if (k == 0) begin
                checks++; if (first !== 7) begin errors++; $display("FAIL press_latency got %0d expected 7", first); end
            end
        end
        load_en = 1'b0;
        @(negedge CLK);
        checks++; if (cpu_hold !== 1'b1) begin errors++; $display("FAIL exit_hold got %b expected 1", cpu_hold); end
        @(negedge CLK);
        checks++; if (cpu_hold !== 1'b0) begin errors++; $display("FAIL exit_run got %b expected 0", cpu_hold); end
        m_load = 1'b0;
        rd_addr = 4'h1; #1;
        checks++; if (rd_data !== 8'h45) begin errors++; $display("FAIL run_fetch1 got %h expected 45", rd_data); end
        for (int a = 0; a < 16; a++) begin
            rd_addr = 4'(a); #1;
            checks++; if (rd_data !== m_mem[a]) begin errors++; $display("FAIL load_mem[%0d] got %h expected %h", a, rd_data, m_mem[a]); end
        end
    endtask

    task automatic test_bounce();
        int acks, first, exp;
        logic [7:0] d;
        go_load();
        for (int g = 0; g < 4; g++) begin
            do_press($urandom_range(1, 3), 8'($urandom), acks, first);
            checks++; if (acks !== 0) begin errors++; $display("FAIL glitch%0d_ack got %0d expected 0", g, acks); end
            checks++; if (wr_ptr !== 4'(m_ptr)) begin errors++; $display("FAIL glitch%0d_ptr got %h expected %h", g, wr_ptr, 4'(m_ptr)); end
        end
        d = 8'($urandom);
        exp = m_press(d);
        do_press(10, d, acks, first);
        checks++; if (acks !== exp) begin errors++; $display("FAIL clean_ack got %0d expected %0d", acks, exp); end
        checks++; if (wr_ptr !== 4'(m_ptr)) begin errors++; $display("FAIL clean_ptr got %h expected %h", wr_ptr, 4'(m_ptr)); end
        rd_addr = 4'h0; #1;
        checks++; if (rd_data !== m_mem[0]) begin errors++; $display("FAIL clean_mem0 got %h expected %h", rd_data, m_mem[0]); end
    endtask

    task automatic test_wrap_full();
        int acks, first, exp;
        go_run();
        go_load();
        for (int i = 0; i < 16; i++) begin
            exp = m_press(8'(i * 17));
            do_press($urandom_range(4, 8), 8'(i * 17), acks, first);
            checks++; if (acks !== exp) begin errors++; $display("FAIL wrap_ack%0d got %0d expected %0d", i, acks, exp); end
            checks++; if (wr_ptr !== 4'(m_ptr)) begin errors++; $display("FAIL wrap_ptr%0d got %h expected %h", i, wr_ptr, 4'(m_ptr)); end
            checks++; if (full !== m_full) begin errors++; $display("FAIL wrap_full%0d got %b expected %b", i, full, m_full); end
        end
        exp = m_press(8'hAA);
        do_press(6, 8'hAA, acks, first);
        checks++; if (acks !== exp) begin errors++; $display("FAIL full_ack got %0d expected %0d", acks, exp); end
        rd_addr = 4'h0; #1;
        checks++; if (rd_data !== 8'h00) begin errors++; $display("FAIL full_mem0 got %h expected 00", rd_data); end
        for (int a = 0; a < 16; a++) begin
            rd_addr = 4'(a); #1;
            checks++; if (rd_data !== m_mem[a]) begin errors++; $display("FAIL wrap_mem[%0d] got %h expected %h", a, rd_data, m_mem[a]); end
        end
        go_run();
        checks++; if (cpu_hold !== 1'b0) begin errors++; $display("FAIL full_exit got %b expected 0", cpu_hold); end
        go_load();
        checks++; if (full !== 1'b0) begin errors++; $display("FAIL reenter_full got %b expected 0", full); end
        checks++; if (wr_ptr !== 4'h0) begin errors++; $display("FAIL reenter_ptr got %h expected 0", wr_ptr); end
    endtask

    task automatic test_ignored();
        int acks, first, exp;
        logic [7:0] d;
        go_run();
        d = 8'($urandom);
        exp = m_press(d);
        do_press(8, d, acks, first);
        checks++; if (acks !== exp) begin errors++; $display("FAIL run_press_ack got %0d expected %0d", acks, exp); end
        for (int a = 0; a < 16; a++) begin
            rd_addr = 4'(a); #1;
            checks++; if (rd_data !== m_mem[a]) begin errors++; $display("FAIL run_mem[%0d] got %h expected %h", a, rd_data, m_mem[a]); end
        end
        go_load();
        // Press pulse reaches the FSM on the same edge that sees load_en low.
        data_in  = 8'($urandom);
        wr_btn_n = 1'b0;
        acks     = 0;
        for (int i = 1; i <= 18; i++) begin
            @(negedge CLK);
            if (wr_ack === 1'b1) acks++;
            if (i == 6) load_en = 1'b0;
            if (i == 7) begin
                checks++; if (cpu_hold !== 1'b1) begin errors++; $display("FAIL simul_hold got %b expected 1", cpu_hold); end
            end
            if (i == 8) begin
                checks++; if (cpu_hold !== 1'b0) begin errors++; $display("FAIL simul_run got %b expected 0", cpu_hold); end
            end
            if (i == 10) wr_btn_n = 1'b1;
        end
        m_load = 1'b0;
        checks++; if (acks !== 0) begin errors++; $display("FAIL simul_ack got %0d expected 0", acks); end
        checks++; if (wr_ptr !== 4'(m_ptr)) begin errors++; $display("FAIL simul_ptr got %h expected %h", wr_ptr, 4'(m_ptr)); end
        rd_addr = 4'h0; #1;
        checks++; if (rd_data !== m_mem[0]) begin errors++; $display("FAIL simul_mem0 got %h expected %h", rd_data, m_mem[0]); end
    endtask

    task automatic test_reset_mid_write();
        bit seen;
        go_load();
        data_in  = 8'($urandom_range(1, 255));
        wr_btn_n = 1'b0;
        seen     = 1'b0;
        for (int i = 1; i <= 12 && !seen; i++) begin
            @(negedge CLK);
            if (wr_ack === 1'b1) begin
                seen = 1'b1;
                RST  = 1'b0;
            end
        end
        wr_btn_n = 1'b1;
        load_en  = 1'b0;
        #1;
        checks++; if (seen !== 1'b1) begin errors++; $display("FAIL midwrite_ack got %b expected 1", seen); end
        m_reset();
        checks++; if (wr_ptr !== 4'h0) begin errors++; $display("FAIL midwrite_ptr got %h expected 0", wr_ptr); end
        checks++; if (cpu_hold !== 1'b1) begin errors++; $display("FAIL midwrite_hold got %b expected 1", cpu_hold); end
        checks++; if (wr_ack !== 1'b0) begin errors++; $display("FAIL midwrite_wr_ack got %b expected 0", wr_ack); end
        for (int a = 0; a < 16; a++) begin
            rd_addr = 4'(a); #1;
            checks++; if (rd_data !== m_mem[a]) begin errors++; $display("FAIL midwrite_mem[%0d] got %h expected %h", a, rd_data, m_mem[a]); end
        end
        repeat (2) @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        checks++; if (cpu_hold !== 1'b0) begin errors++; $display("FAIL midwrite_release got %b expected 0", cpu_hold); end
    endtask

    task automatic test_random_session();
        int acks, first, exp, op;
        logic [7:0] d;
        for (int k = 0; k < 30; k++) begin
            op = $urandom_range(0, 9);
            if (op == 0) begin
                if (m_load) go_run(); else go_load();
                checks++; if (cpu_hold !== m_load) begin errors++; $display("FAIL rnd%0d_mode got %b expected %b", k, cpu_hold, m_load); end
            end else begin
                d = 8'($urandom);
                if (op <= 2) begin
                    exp = 0;
                    do_press($urandom_range(1, 3), d, acks, first);
                end else begin
                    exp = m_press(d);
                    do_press($urandom_range(4, 12), d, acks, first);
                end
                checks++; if (acks !== exp) begin errors++; $display("FAIL rnd%0d_ack got %0d expected %0d", k, acks, exp); end
            end
            checks++; if (wr_ptr !== 4'(m_ptr)) begin errors++; $display("FAIL rnd%0d_ptr got %h expected %h", k, wr_ptr, 4'(m_ptr)); end
            checks++; if (full !== m_full) begin errors++; $display("FAIL rnd%0d_full got %b expected %b", k, full, m_full); end
        end
        go_run();
        for (int a = 0; a < 16; a++) begin
            rd_addr = 4'(a); #1;
            checks++; if (rd_data !== m_mem[a]) begin errors++; $display("FAIL rnd_mem[%0d] got %h expected %h", a, rd_data, m_mem[a]); end
        end
    endtask

    initial begin
        test_reset();
        test_load_run();
        test_bounce();
        test_wrap_full();
        test_ignored();
        test_reset_mid_write();
        test_random_session();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
